csa_sub_seq: RTL and testbench
==============================

// Module: csa_sub_seq
// PURPOSE
//   Multi-cycle N-bit subtractor. Computes a - b - bw_in one CHUNK-bit slice per clock.
//   Each slice uses a borrow-select scheme: both borrow-0 and borrow-1 differences are
//   formed, then the registered borrow from the previous slice picks one. This is the
//   subtract/inverse counterpart of the 4-bit carry-select adder datapath. Its
//   start/busy/done handshake lets wide operands share one narrow slice datapath.
// PARAMETERS
//   WIDTH  16  operand/result width; must be a multiple of CHUNK
//   CHUNK  4   bits processed per clock; N = WIDTH/CHUNK slices
// PORTS
//   clk    in   1      rising-edge clock
//   rst    in   1      asynchronous, active-high reset
//   start  in   1      request; sampled only in IDLE
//   a      in   WIDTH  minuend, latched on accepted start
//   b      in   WIDTH  subtrahend, latched on accepted start
//   bw_in  in   1      borrow in, latched on accepted start
//   busy   out  1      high while state==RUN
//   done   out  1      one-cycle pulse; result valid
//   d      out  WIDTH  difference, registered, held until next completion
//   bw_out out  1      unsigned borrow out (a < b + bw_in)
//   ovf    out  1      two's-complement overflow of a - b - bw_in
// BEHAVIOUR
//   - Reset (any time, incl. mid-operation): state=IDLE, slice counter=0; busy=0,
//     done=0, d=0, bw_out=0, ovf=0. Any partial result is discarded.
//   - States:
//     - IDLE: start=1 -> latch a, b, bw_in; borrow reg = bw_in; cnt=0; go to RUN.
//     - RUN: each edge computes slice cnt (bits [cnt*CHUNK +: CHUNK]):
//       - diff0 = a_s - b_s; diff1 = a_s - b_s - 1. Both are CHUNK+1 bits; the MSB is
//         the borrow.
//       - Select by the borrow reg. Write the slice into the internal accumulator
//         (not d). Update the borrow reg. cnt++.
//       - When cnt==N-1 is processed, go to DONE. On that same edge, load d from the
//         accumulator, bw_out from the final borrow, and ovf.
//     - DONE: done=1 for exactly one cycle, then IDLE unconditionally.
//   - ovf = (a[W-1] != b[W-1]) && (d[W-1] != a[W-1]), using the latched operands.
//   - Latency: start sampled on edge E -> done high in the cycle after edge E+N.
//     WIDTH=16, CHUNK=4 gives 4 cycles. Throughput: one operation per N+2 cycles.
//   - start while busy or in DONE: ignored, no queuing. Inputs a/b/bw_in may change
//     freely after the accepting edge.
//   - All arithmetic is modulo 2^WIDTH. No sign extension is done internally.
//   - d/bw_out/ovf change only on the RUN->DONE edge or on reset.
// CONFIGURATION
//   CSA_SUB_ADD_MODE_EN
//   - Defined: adds input port `sub` (1 bit), latched with the operands on start.
//     - sub=1: behaviour as above.
//     - sub=0: computes a + b + bw_in using the carry-select form (slices a_s+b_s+0 and
//       a_s+b_s+1). bw_out carries the carry out; ovf is signed add overflow
//       (a[W-1]==b[W-1] && d[W-1]!=a[W-1]).
//   - Undefined: no `sub` port; always subtracts.
// TESTING (WIDTH=16, CHUNK=4)
//   1. a=0x1234 b=0x0235 bw_in=0, start 1 cycle -> busy 4 cycles, then done pulse;
//      d=0x0FFF, bw_out=0, ovf=0.
//   2. a=0x0000 b=0x0001 bw_in=0 -> d=0xFFFF, bw_out=1, ovf=0 (borrow ripples through
//      all 4 slices).
//   3. a=0x8000 b=0x0001 bw_in=0 -> d=0x7FFF, bw_out=0, ovf=1.
//   4. a=0x0005 b=0x0005 bw_in=1 -> d=0xFFFF, bw_out=1. Then start with
//      a=0x0005 b=0x0005 bw_in=0 -> d=0x0000, bw_out=0.
//   5. Case 1 running; at RUN cycle 2 apply start with a=0xFFFF b=0 -> ignored; result
//      still d=0x0FFF and exactly one done pulse. Hold start high through DONE -> a new
//      operation is accepted only on the edge after returning to IDLE.
//   6. Start case 2, assert rst during RUN cycle 2 -> busy, done, d, bw_out, ovf all 0
//      immediately (async). After release, no done pulse until a new start. With
//      CSA_SUB_ADD_MODE_EN and sub=0: a=0x7FFF b=0x0001 -> d=0x8000, bw_out=0, ovf=1.

Source files
------------

// File: rtl/csa_sub_seq.sv
// rtl/csa_sub_seq.sv - Multi-cycle borrow-select subtractor, CHUNK bits per clock (optional CSA_SUB_ADD_MODE_EN add mode)
module csa_sub_seq #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bw_in,
`ifdef CSA_SUB_ADD_MODE_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] d,
    output logic             bw_out,
    output logic             ovf
);

    localparam int N  = WIDTH / CHUNK;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             brw_q, brw_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic             bwo_q, bwo_d;
    logic             ovf_q, ovf_d;
    logic             is_sub;

`ifdef CSA_SUB_ADD_MODE_EN
    logic             sub_q, sub_d;
    assign is_sub = sub_q;
`else
    assign is_sub = 1'b1;
`endif

    // Slice datapath: both borrow/carry candidates are formed, the registered borrow picks one
    logic [CHUNK-1:0] a_s, b_s;
    logic [CHUNK:0]   r0, r1, sel;
    logic [WIDTH-1:0] acc_next;
    logic             ovf_calc;

    // Form the current slice result and the accumulator with that slice merged in
    always_comb begin
        a_s = a_q[cnt_q*CHUNK +: CHUNK];
        b_s = b_q[cnt_q*CHUNK +: CHUNK];
        if (is_sub) begin
            r0 = {1'b0, a_s} - {1'b0, b_s};
            r1 = r0 - {{CHUNK{1'b0}}, 1'b1};
        end else begin
            r0 = {1'b0, a_s} + {1'b0, b_s};
            r1 = r0 + {{CHUNK{1'b0}}, 1'b1};
        end
        sel      = brw_q ? r1 : r0;
        acc_next = acc_q;
        acc_next[cnt_q*CHUNK +: CHUNK] = sel[CHUNK-1:0];
        if (is_sub)
            ovf_calc = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (acc_next[WIDTH-1] != a_q[WIDTH-1]);
        else
            ovf_calc = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (acc_next[WIDTH-1] != a_q[WIDTH-1]);
    end

    // Next-state and datapath-register updates; results only move on the last RUN edge
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        brw_d   = brw_q;
        acc_d   = acc_q;
        d_d     = d_q;
        bwo_d   = bwo_q;
        ovf_d   = ovf_q;
`ifdef CSA_SUB_ADD_MODE_EN
        sub_d   = sub_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    brw_d   = bw_in;
                    cnt_d   = '0;
                    acc_d   = '0;
`ifdef CSA_SUB_ADD_MODE_EN
                    sub_d   = sub;
`endif
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                acc_d = acc_next;
                brw_d = sel[CHUNK];
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    cnt_d   = '0;
                    d_d     = acc_next;
                    bwo_d   = sel[CHUNK];
                    ovf_d   = ovf_calc;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers; reset discards any partial operation
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            brw_q   <= 1'b0;
            acc_q   <= '0;
            d_q     <= '0;
            bwo_q   <= 1'b0;
            ovf_q   <= 1'b0;
`ifdef CSA_SUB_ADD_MODE_EN
            sub_q   <= 1'b1;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            brw_q   <= brw_d;
            acc_q   <= acc_d;
            d_q     <= d_d;
            bwo_q   <= bwo_d;
            ovf_q   <= ovf_d;
`ifdef CSA_SUB_ADD_MODE_EN
            sub_q   <= sub_d;
`endif
        end
    end

    assign busy   = (state_q == ST_RUN);
    assign done   = (state_q == ST_DONE);
    assign d      = d_q;
    assign bw_out = bwo_q;
    assign ovf    = ovf_q;

endmodule

// File: tb/tb_csa_sub_seq.sv
// tb/tb_csa_sub_seq.sv - Self-checking bench for csa_sub_seq with a cycle-level arithmetic model
module tb_csa_sub_seq;

    localparam int W = 16;
    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         bw_in = 1'b0;
    logic         sub = 1'b1;
    logic         busy, done, bw_out, ovf;
    logic [W-1:0] d;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    csa_sub_seq #(.WIDTH(W), .CHUNK(4)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .a      (a),
        .b      (b),
        .bw_in  (bw_in),
`ifdef CSA_SUB_ADD_MODE_EN
        .sub    (sub),
`endif
        .busy   (busy),
        .done   (done),
        .d      (d),
        .bw_out (bw_out),
        .ovf    (ovf)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Plain-integer reference: exact result, then derive wrap, borrow/carry and signed overflow
    function automatic logic [17:0] ref_op(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic c, input logic is_sub);
        int ux, uy, sx, sy, exact, sexact;
        logic [W-1:0] r;
        logic bo, ov;
        ux = int'(x);
        uy = int'(y);
        sx = (ux >= 32768) ? ux - 65536 : ux;
        sy = (uy >= 32768) ? uy - 65536 : uy;
        if (is_sub) begin
            exact  = ux - uy - int'(c);
            sexact = sx - sy - int'(c);
            bo     = (ux < uy + int'(c));
        end else begin
            exact  = ux + uy + int'(c);
            sexact = sx + sy + int'(c);
            bo     = (exact > 65535);
        end
        r  = W'(exact);
        ov = (sexact > 32767) || (sexact < -32768);
        return {ov, bo, r};
    endfunction

    int           left_m = 0;
    logic         done_m = 1'b0;
    logic [17:0]  pend_m = '0;
    logic [17:0]  out_m  = '0;

    // Model: accept in idle, N busy cycles, one done cycle, then idle
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            left_m <= 0;
            done_m <= 1'b0;
            out_m  <= '0;
        end else if (done_m) begin
            done_m <= 1'b0;
        end else if (left_m > 0) begin
            left_m <= left_m - 1;
            if (left_m == 1) begin
                done_m <= 1'b1;
                out_m  <= pend_m;
            end
        end else if (start) begin
`ifdef CSA_SUB_ADD_MODE_EN
            pend_m <= ref_op(a, b, bw_in, sub);
`else
            pend_m <= ref_op(a, b, bw_in, 1'b1);
`endif
            left_m <= N;
        end
    end

    // Every-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        check("busy", 32'(busy), 32'(left_m > 0));
        check("done", 32'(done), 32'(done_m));
        check("d", 32'(d), 32'(out_m[15:0]));
        check("bw_out", 32'(bw_out), 32'(out_m[16]));
        check("ovf", 32'(ovf), 32'(out_m[17]));
    end

    task automatic launch(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        @(negedge clk);
        a = x; b = y; bw_in = c; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(output int busy_cycles);
        bit seen;
        seen = 0;
        busy_cycles = 1;
        for (int i = 0; i < 30; i++) begin
            if (done) begin
                seen = 1;
                break;
            end
            @(negedge clk);
            if (busy) busy_cycles++;
        end
        if (!seen) begin
            errors++;
            checks++;
            $display("FAIL done_timeout: got no done pulse within 30 cycles");
        end
    endtask

    int bc;
    int pulses;
    logic [17:0] m;

    initial begin
        // Model pinned against hand-computed values
        m = ref_op(16'h1234, 16'h0235, 1'b0, 1'b1);
        check("model_c1", 32'(m), 32'({2'b00, 16'h0FFF}));
        m = ref_op(16'h8000, 16'h0001, 1'b0, 1'b1);
        check("model_c3", 32'(m), 32'({2'b10, 16'h7FFF}));
        m = ref_op(16'h7FFF, 16'h0001, 1'b0, 1'b0);
        check("model_add", 32'(m), 32'({2'b10, 16'h8000}));

        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_d", 32'(d), 32'd0);
        rst = 1'b0;

        // Case 1
        launch(16'h1234, 16'h0235, 1'b0);
        wait_done(bc);
        check("c1_busy_cycles", 32'(bc), 32'd4);
        check("c1_d", 32'(d), 32'h0FFF);
        check("c1_bw", 32'(bw_out), 32'd0);
        check("c1_ovf", 32'(ovf), 32'd0);

        // Case 2: borrow ripples through every slice
        launch(16'h0000, 16'h0001, 1'b0);
        wait_done(bc);
        check("c2_d", 32'(d), 32'hFFFF);
        check("c2_bw", 32'(bw_out), 32'd1);
        check("c2_ovf", 32'(ovf), 32'd0);

        // Case 3: signed overflow
        launch(16'h8000, 16'h0001, 1'b0);
        wait_done(bc);
        check("c3_d", 32'(d), 32'h7FFF);
        check("c3_bw", 32'(bw_out), 32'd0);
        check("c3_ovf", 32'(ovf), 32'd1);

        // Case 4: borrow-in effect
        launch(16'h0005, 16'h0005, 1'b1);
        wait_done(bc);
        check("c4a_d", 32'(d), 32'hFFFF);
        check("c4a_bw", 32'(bw_out), 32'd1);
        launch(16'h0005, 16'h0005, 1'b0);
        wait_done(bc);
        check("c4b_d", 32'(d), 32'h0000);
        check("c4b_bw", 32'(bw_out), 32'd0);

        // Case 5: start while busy is ignored; held start re-accepted only from idle
        launch(16'h1234, 16'h0235, 1'b0);
        a = 16'hFFFF; b = 16'h0000; start = 1'b1;
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            if (done) pulses++;
            if (i < 4) @(negedge clk);
        end
        check("c5_pulses", 32'(pulses), 32'd1);
        check("c5_d", 32'(d), 32'h0FFF);
        @(negedge clk);
        check("c5_idle_busy", 32'(busy), 32'd0);
        check("c5_idle_done", 32'(done), 32'd0);
        @(negedge clk);
        check("c5_reaccept", 32'(busy), 32'd1);
        start = 1'b0;
        wait_done(bc);
        check("c5b_d", 32'(d), 32'hFFFF);

        // Case 6: asynchronous reset mid-run
        launch(16'h0000, 16'h0001, 1'b0);
        #2 rst = 1'b1;
        #1;
        check("c6_busy", 32'(busy), 32'd0);
        check("c6_done", 32'(done), 32'd0);
        check("c6_d", 32'(d), 32'd0);
        check("c6_bw", 32'(bw_out), 32'd0);
        check("c6_ovf", 32'(ovf), 32'd0);
        @(negedge clk);
        #2 rst = 1'b0;
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done || busy) pulses++;
        end
        check("c6_quiet", 32'(pulses), 32'd0);

`ifdef CSA_SUB_ADD_MODE_EN
        sub = 1'b0;
        launch(16'h7FFF, 16'h0001, 1'b0);
        wait_done(bc);
        check("add_d", 32'(d), 32'h8000);
        check("add_co", 32'(bw_out), 32'd0);
        check("add_ovf", 32'(ovf), 32'd1);
        sub = 1'b1;
`endif

        repeat (3) @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
